// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arbiter: ALUControl codes, FSM states, requester ids.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
            default:                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared 32-bit combinational ALU; illegal control codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ALUControl,
    output logic [31:0] y
);

    // Result select; add/sub wrap modulo 2^32, SLT compares signed operands
    always_comb begin
        y = 32'd0;
        case (ALUControl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: y = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU, one transaction in flight.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie (default: round-robin).
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_y,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_y,
    output logic        rsp1_err
);

    state_t      r_state;
`ifndef ALU_ARB_FIXED_PRIO_EN
    req_id_t     r_last;
`endif
    logic        r_rsp0_valid;
    logic [31:0] r_rsp0_y;
    logic        r_rsp0_err;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp1_y;
    logic        r_rsp1_err;

    req_id_t     w_grant;
    logic        w_can_accept;
    logic        w_accept;
    logic        w_rsp_hs;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [2:0]  w_op;
    logic [31:0] w_y;
    logic        w_err;

    // Grant selection; a tie goes to the requester not served last
    always_comb begin
        w_grant = REQ_0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (req0_valid) begin
            w_grant = REQ_0;
        end else if (req1_valid) begin
            w_grant = REQ_1;
        end else begin
            w_grant = REQ_0;
        end
`else
        if (req0_valid && req1_valid) begin
            w_grant = (r_last == REQ_1) ? REQ_0 : REQ_1;
        end else if (req1_valid) begin
            w_grant = REQ_1;
        end else begin
            w_grant = REQ_0;
        end
`endif
    end

    // Ready only in IDLE, outside reset, and only towards the granted requester
    always_comb begin
        w_can_accept = (r_state == ST_IDLE) && !reset;
        req0_ready   = w_can_accept && req0_valid && (w_grant == REQ_0);
        req1_ready   = w_can_accept && req1_valid && (w_grant == REQ_1);
        w_accept     = req0_ready || req1_ready;
        w_rsp_hs     = (r_rsp0_valid && rsp0_ready) || (r_rsp1_valid && rsp1_ready);
    end

    // Operand mux feeding the single shared ALU
    always_comb begin
        if (w_grant == REQ_1) begin
            w_a  = req1_a;
            w_b  = req1_b;
            w_op = req1_op;
        end else begin
            w_a  = req0_a;
            w_b  = req0_b;
            w_op = req0_op;
        end
        w_err = !op_is_legal(w_op);
    end

    alu u_alu (
        .a          (w_a),
        .b          (w_b),
        .ALUControl (w_op),
        .y          (w_y)
    );

    // Transaction FSM; per-requester response registers stay zero for the non-owner
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last       <= REQ_1;
`endif
            r_rsp0_valid <= 1'b0;
            r_rsp0_y     <= 32'd0;
            r_rsp0_err   <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_y     <= 32'd0;
            r_rsp1_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_HOLD;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last       <= w_grant;
`endif
                        r_rsp0_valid <= (w_grant == REQ_0);
                        r_rsp0_y     <= (w_grant == REQ_0) ? w_y : 32'd0;
                        r_rsp0_err   <= (w_grant == REQ_0) && w_err;
                        r_rsp1_valid <= (w_grant == REQ_1);
                        r_rsp1_y     <= (w_grant == REQ_1) ? w_y : 32'd0;
                        r_rsp1_err   <= (w_grant == REQ_1) && w_err;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // Handshake cycle never also accepts: that waits for IDLE
                    if (w_rsp_hs) begin
                        r_state      <= ST_IDLE;
                        r_rsp0_valid <= 1'b0;
                        r_rsp0_y     <= 32'd0;
                        r_rsp0_err   <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_rsp1_y     <= 32'd0;
                        r_rsp1_err   <= 1'b0;
                    end else begin
                        r_state      <= ST_HOLD;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_rsp0_valid <= 1'b0;
                    r_rsp0_y     <= 32'd0;
                    r_rsp0_err   <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_rsp1_y     <= 32'd0;
                    r_rsp1_err   <= 1'b0;
                end
            endcase
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_y     = r_rsp0_y;
    assign rsp0_err   = r_rsp0_err;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_y     = r_rsp1_y;
    assign rsp1_err   = r_rsp1_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter; expected values are hand-computed constants.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic [31:0] req0_a, req0_b, rsp0_y;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] req1_a, req1_b, rsp1_y;
    logic [2:0]  req1_op;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_y     (rsp0_y),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_y     (rsp1_y),
        .rsp1_err   (rsp1_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 3'b000; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 3'b000; rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); end
        n_vec++; if ({rsp0_y, rsp1_y, rsp0_err, rsp1_err} !== 66'd0) begin n_err++; $display("FAIL reset_rsp_data: got %h %h %b %b expected zeros", rsp0_y, rsp1_y, rsp0_err, rsp1_err); end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFB; req0_b = 32'd3; req0_op = 3'b000;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        n_vec++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL add_rsp_valid: got %b expected 1", rsp0_valid); end
        n_vec++; if (rsp0_y !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL add_y: got %h expected fffffffe", rsp0_y); end
        n_vec++; if (rsp0_err !== 1'b0) begin n_err++; $display("FAIL add_err: got %b expected 0", rsp0_err); end
        n_vec++; if ({rsp1_valid, rsp1_y, rsp1_err} !== 34'd0) begin n_err++; $display("FAIL add_nonowner: got %b %h %b expected zeros", rsp1_valid, rsp1_y, rsp1_err); end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        n_vec++; if ({rsp0_valid, rsp0_y} !== 33'd0) begin n_err++; $display("FAIL add_release: got %b %h expected 0 0", rsp0_valid, rsp0_y); end
    endtask

    task automatic test_round_robin();
        int exp_id;
        logic [31:0] got_y;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd6; req0_op = 3'b001; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd6; req1_op = 3'b001; rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = i % 2;
`endif
            n_vec++; if ({req0_ready, req1_ready} !== {exp_id == 0, exp_id == 1}) begin n_err++; $display("FAIL rr_grant%0d: got %b expected id %0d", i, {req0_ready, req1_ready}, exp_id); end
            tick();
            got_y = (exp_id == 1) ? rsp1_y : rsp0_y;
            n_vec++; if ({rsp0_valid, rsp1_valid} !== {exp_id == 0, exp_id == 1}) begin n_err++; $display("FAIL rr_owner%0d: got %b expected id %0d", i, {rsp0_valid, rsp1_valid}, exp_id); end
            n_vec++; if (got_y !== 32'd4) begin n_err++; $display("FAIL rr_y%0d: got %h expected 4", i, got_y); end
            n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rr_hold_ready%0d: got %b expected 00", i, {req0_ready, req1_ready}); end
            tick();
            n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rr_drop%0d: got %b expected 00", i, {rsp0_valid, rsp1_valid}); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_slt();
        logic [31:0] va [0:1] = '{32'hFFFF_FFFB, 32'd3};
        logic [31:0] vb [0:1] = '{32'd3, 32'hFFFF_FFFB};
        logic [31:0] vy [0:1] = '{32'd1, 32'd0};
        for (int i = 0; i < 2; i++) begin
            req1_valid = 1'b1; req1_a = va[i]; req1_b = vb[i]; req1_op = 3'b101;
            #1;
            n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL slt_ready%0d: got %b expected 01", i, {req0_ready, req1_ready}); end
            tick();
            req1_valid = 1'b0;
            n_vec++; if ({rsp1_valid, rsp1_y, rsp1_err} !== {1'b1, vy[i], 1'b0}) begin n_err++; $display("FAIL slt_rsp%0d: got %b %h %b expected 1 %h 0", i, rsp1_valid, rsp1_y, rsp1_err, vy[i]); end
            n_vec++; if ({rsp0_valid, rsp0_y, rsp0_err} !== 34'd0) begin n_err++; $display("FAIL slt_nonowner%0d: got %b %h %b expected zeros", i, rsp0_valid, rsp0_y, rsp0_err); end
            rsp1_ready = 1'b1;
            tick();
            rsp1_ready = 1'b0;
            n_vec++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL slt_release%0d: got %b expected 0", i, rsp1_valid); end
        end
    endtask

    task automatic test_ops_and_illegal();
        logic [2:0]  vop [0:6] = '{3'b110, 3'b011, 3'b100, 3'b111, 3'b000, 3'b001, 3'b010};
        logic [31:0] va  [0:6] = '{32'd7, 32'h0000_00F0, 32'd5, 32'd9, 32'h7FFF_FFFF, 32'd0, 32'hFF00_FF00};
        logic [31:0] vb  [0:6] = '{32'd9, 32'h0000_000F, 32'd5, 32'd1, 32'd1, 32'd1, 32'h0FF0_0FF0};
        logic [31:0] vy  [0:6] = '{32'd0, 32'h0000_00FF, 32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0F00_0F00};
        logic        ve  [0:6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i]; req0_op = vop[i];
            tick();
            req0_valid = 1'b0;
            n_vec++; if ({rsp0_valid, rsp0_y, rsp0_err} !== {1'b1, vy[i], ve[i]}) begin n_err++; $display("FAIL op%0d_%b: got %b %h %b expected 1 %h %b", i, vop[i], rsp0_valid, rsp0_y, rsp0_err, vy[i], ve[i]); end
            rsp0_ready = 1'b1;
            tick();
            rsp0_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back_stall();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
        tick();
        req0_a = 32'd100;
        req1_valid = 1'b1; req1_a = 32'd50; req1_b = 32'd50; req1_op = 3'b000;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if ({rsp0_valid, rsp0_y} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL stall_y%0d: got %b %h expected 1 00000003", i, rsp0_valid, rsp0_y); end
            n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL stall_ready%0d: got %b expected 00", i, {req0_ready, req1_ready}); end
            tick();
        end
        idle_inputs();
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_reset_in_hold();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_op = 3'b000;
        tick();
        reset = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b000;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_hold_ready: got %b expected 00", {req0_ready, req1_ready}); end
        tick();
        reset = 1'b0;
        #1;
        n_vec++; if ({rsp0_valid, rsp0_y, rsp1_valid} !== 34'd0) begin n_err++; $display("FAIL rst_hold_discard: got %b %h %b expected zeros", rsp0_valid, rsp0_y, rsp1_valid); end
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rst_hold_tie: got %b expected 10", {req0_ready, req1_ready}); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_slt();
        test_ops_and_illegal();
        test_back_to_back_stall();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
